// File: rtl/dreg_pkg.sv
// Shared constants, FSM state type and the mirror-aware address match
// used by the register-file write scheduler.
package dreg_pkg;

  localparam int RF_AW     = 5;
  localparam int RF_N      = 32;
  localparam int RF_MIRROR = 16;

  typedef enum logic {IDLE, SWEEP} sched_state_t;

  // A write to wa also lands at wa+16 when wa is in the low half.
  function automatic logic mirror_hit(input logic [RF_AW-1:0] wa,
                                      input logic [RF_AW-1:0] ra);
    return (wa == ra) ||
           ((int'(wa) < RF_MIRROR) && ({1'b1, wa[RF_AW-2:0]} == ra));
  endfunction

endpackage

// File: rtl/dreg_wsched_rr_arb.sv
// Round-robin grant over NREQ requesters; pointer moves past each winner.
module rr_arb #(
  parameter int NREQ = 2,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [NREQ-1:0] valid,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   gnt_idx,
  output logic            gnt_any
);

  logic [PW-1:0] ptr;
  int            j;

  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    j       = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (en && !gnt_any && valid[j]) begin
        gnt_any  = 1'b1;
        grant[j] = 1'b1;
        gnt_idx  = PW'(j);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr <= '0;
    else if (gnt_any)
      ptr <= (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
  end

endmodule

// File: rtl/dreg_wsched.sv
// Write-port scheduler for the mirrored register file: round-robin write
// sharing, one registered write stage, read bypass and a clear sweep.
`ifndef BITNESS
`define BITNESS 32
`endif

module dreg_wsched
  import dreg_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int DW   = `BITNESS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*RF_AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0]    req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  hold,
  input  logic                  clr_req,
  output logic                  clr_busy,
  output logic                  clr_done,
  output logic                  wr_en,
  output logic [RF_AW-1:0]      wr_addr,
  output logic [DW-1:0]         wr_data,
  input  logic [RF_AW-1:0]      rd_addr,
  output logic [RF_AW-1:0]      rf_ra,
  input  logic [DW-1:0]         rf_rval,
  output logic [DW-1:0]         rd_data
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  sched_state_t     state, state_n;
  logic [3:0]       cnt, cnt_n;
  logic             done_n, wen_n, arb_en, gnt_any;
  logic [RF_AW-1:0] waddr_n;
  logic [DW-1:0]    wdata_n;
  logic [PW-1:0]    gnt_idx;
  logic [NREQ-1:0]  grant;

  // rst_n gating keeps req_ready low for the whole reset assertion.
  assign arb_en = rst_n && (state == IDLE) && !hold;

  rr_arb #(.NREQ(NREQ), .PW(PW)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (arb_en),
    .valid   (req_valid),
    .grant   (grant),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign req_ready = grant;
  assign clr_busy  = (state == SWEEP);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    done_n  = 1'b0;
    wen_n   = 1'b0;
    waddr_n = wr_addr;
    wdata_n = wr_data;
    case (state)
      IDLE: begin
        // A grant in the clr_req cycle still completes.
        if (gnt_any) begin
          wen_n   = 1'b1;
          waddr_n = req_addr[int'(gnt_idx)*RF_AW +: RF_AW];
          wdata_n = req_data[int'(gnt_idx)*DW +: DW];
        end
        if (clr_req) begin
          state_n = SWEEP;
          cnt_n   = '0;
        end
      end
      SWEEP: begin
        // Only the low half is swept; the mirror clears the upper half.
        if (!hold) begin
          wen_n   = 1'b1;
          waddr_n = {1'b0, cnt};
          wdata_n = '0;
          cnt_n   = cnt + 4'd1;
          if (cnt == 4'hF) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      clr_done <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      clr_done <= done_n;
      wr_en    <= wen_n;
      wr_addr  <= waddr_n;
      wr_data  <= wdata_n;
    end
  end

  assign rf_ra = rd_addr;

  always_comb begin
    rd_data = rf_rval;
    if (wr_en && mirror_hit(wr_addr, rd_addr)) rd_data = wr_data;
  end

endmodule

// File: doc/dreg_wsched.md
Name: dreg_wsched

Overview:
Write-port scheduler and read-bypass controller for the 32-entry mirrored register file (single write port w/wa/wval, single combinational read port ra/rval; a write to addr<16 also lands at addr+16).
- Shares the one write port among NREQ requesters using round-robin arbitration with a valid/ready handshake.
- Drives the write through one registered stage and forwards in-flight write data to the read path.
- Provides a clear-sweep state machine that zeroes the file without a reset.

Parameters:
NREQ, 2, number of write requesters (2..4)
DW, `BITNESS, data word width (matches `WORD)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  requester i has a write pending
req_addr  in  NREQ*5  requester i target address, slice [i*5+:5]
req_data  in  NREQ*DW  requester i write data, slice [i*DW+:DW]
req_ready  out  NREQ  requester i accepted this cycle when valid&&ready
hold  in  1  freeze: no grants, sweep paused
clr_req  in  1  single-cycle pulse, start clear sweep
clr_busy  out  1  sweep in progress
clr_done  out  1  one-cycle pulse after last sweep write issued
wr_en  out  1  to register file w
wr_addr  out  5  to register file wa
wr_data  out  DW  to register file wval
rd_addr  in  5  consumer read address
rf_ra  out  5  to register file ra (=rd_addr, combinational)
rf_rval  in  DW  from register file rval
rd_data  out  DW  forwarded read data

Behaviour:
- Reset (rst_n low, async): wr_en=0, wr_addr=0, wr_data=0, rr pointer=0, state=IDLE, sweep counter=0, clr_busy=0, clr_done=0. req_ready=0 while in reset.
- States: IDLE and SWEEP.
- IDLE, arbitration:
  - When hold=0, grant the first valid requester scanning from rr pointer p upward, modulo NREQ.
  - req_ready is one-hot on the granted requester and combinational from req_valid, p, hold and state.
  - On grant to requester i, p <= (i+1)%NREQ. With no grant, p is unchanged.
- Write stage: at the accepting edge, wr_en<=1, wr_addr<=req_addr[i], wr_data<=req_data[i]. With no acceptance, wr_en<=0 and addr/data hold their values.
- Latency: request accepted at edge N appears on wr_* in cycle N..N+1; the register file commits at edge N+1. Throughput is one write per cycle.
- Same-address requests in one cycle: only the granted requester proceeds; the others wait.
- clr_req in IDLE: go to SWEEP at next edge, counter=0, clr_busy=1. No grants while clr_busy=1.
  - If clr_req coincides with an IDLE grant, the grant completes in that same cycle and the sweep starts next cycle.
  - clr_req while in SWEEP is ignored.
- SWEEP:
  - Each cycle with hold=0: wr_en<=1, wr_addr<=counter, wr_data<=0, counter++.
  - Only addresses 0..15 are written; the mirror clears 16..31.
  - With hold=1: wr_en<=0 and the counter is frozen.
  - After issuing addr 15, go to IDLE, clr_busy<=0, clr_done<=1 for exactly one cycle. Grants are allowed from the next cycle.
- Bypass:
  - rd_data = wr_data when wr_en=1 and (wr_addr==rd_addr, or (wr_addr<16 and {1'b1,wr_addr[3:0]}==rd_addr)); otherwise rd_data = rf_rval.
  - The comparison is 5-bit; addr+16 never wraps because it is taken only when addr<16.
- Reset mid-sweep: all state returns to reset values immediately; the sweep is abandoned and no clr_done pulse is issued.

Decomposition:
- Package dreg_pkg:
  - RF_AW=5, RF_N=32, RF_MIRROR=16
  - sched_state_t enum {IDLE,SWEEP}
  - function mirror_hit(wa,ra)
- Sub-module rr_arb (NREQ-wide round-robin grant, pointer update) is the one natural split; the write stage, FSM and bypass live in dreg_wsched.

Test Plan:
- Reset then req0 valid addr 3 data 'hA5 -> req_ready[0]=1 same cycle; next cycle wr_en=1, wr_addr=3, wr_data='hA5; file reads 'hA5 at both 3 and 19.
- req0 and req1 held valid continuously -> grants alternate 0,1,0,1; wr_addr sequence matches; no requester starved.
- wr_en pending addr 5 data 'h77, rd_addr=21 -> rd_data='h77 that cycle; rd_addr=5 -> 'h77; rd_addr=20 with pending addr 20 -> 'h77; pending addr 20 with rd_addr=4 -> rf_rval.
- clr_req with both requesters valid -> clr_busy=1 for 16 cycles, wr_addr 0..15 with data 0, req_ready=0 throughout, clr_done pulses once, grants resume next cycle.
- hold=1 for 3 cycles mid-sweep at counter 7 -> wr_en=0 for those cycles, sweep resumes at 7, total sweep length 19 cycles.
- rst_n low mid-sweep at counter 9 -> outputs at reset values immediately, no clr_done pulse, state IDLE after release.
